regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Shares the CPU's single register file between two requesters: the core pipeline (port C) and a debug/monitor port (port D).
- The register file has 16 entries with 4-bit addresses, x0 hardwired to zero, one write port, two registered read ports with 1-cycle latency, and read/write enables.
- The block arbitrates per cycle, drives the register file controls, and routes read data back to the granted requester one cycle later.
- Fixed priority to the core, with a starvation guard for debug.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles D may be refused while C wins; after that D gets priority. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- c_valid  in  1  core request valid
- c_ready  out  1  core request accepted this cycle
- c_we  in  1  core request includes write
- c_re  in  1  core request includes read
- c_rs1, c_rs2, c_rd  in  4 each  core addresses
- c_wdata  in  32  core write data
- c_rsp_valid  out  1  core read data valid
- c_rdata1, c_rdata2  out  32 each  core read data
- d_valid, d_ready, d_we, d_re, d_rs1, d_rs2, d_rd, d_wdata, d_rsp_valid, d_rdata1, d_rdata2: same as the c_ set, for the debug port
- rf_we, rf_re  out  1 each  register file enables
- rf_rs1, rf_rs2, rf_rd  out  4 each  register file addresses
- rf_wdata  out  32  register file write data
- rf_rdata1, rf_rdata2  in  32 each  register file read data, valid 1 cycle after rf_re

Behaviour:
- **Grant rule:** at most one requester is granted per cycle. A request is accepted when x_valid && x_ready in the same cycle. Both write and read of an accepted request issue in that same cycle.
- **Priority:**
  - Default: C wins when both are valid.
  - starve_cnt increments each cycle that d_valid is high and C is granted. It clears on a D grant or when d_valid is low. It saturates at STARVE_LIMIT.
  - When starve_cnt == STARVE_LIMIT and d_valid is high, D wins that cycle.
- **Ready signals:** c_ready and d_ready are combinational from the valids and starve_cnt. Neither depends on its own requester's other inputs. The loser's ready is 0.
- **Register file drive:** the rf_* outputs are combinational muxes of the granted requester's fields.
  - rf_we = granted && x_we.
  - rf_re = granted && x_re.
  - With no grant: rf_we = rf_re = 0 and all addresses and data = 0.
- **Response:**
  - The owner and the read flag are registered at grant time.
  - In the cycle after a granted read, the owner's x_rsp_valid = 1 and x_rdata1/2 = rf_rdata1/2. The other port's rsp_valid = 0.
  - There is no response backpressure: the requester must sample in that cycle.
  - Back-to-back reads from either port are fully pipelined, at 1 request per cycle.
- **Write-only requests:** these produce no response.
- **x0 handling:**
  - x_rd == 0 with x_we: the request is still accepted and rf_we is still driven; the register file ignores it.
  - Reads of address 0 return 0 from the register file.
- **Same-cycle read and write of one address:** without the optional feature, the response returns the old register value.
- **Reset:**
  - All registered state clears: starve_cnt = 0, the response pipeline is empty, and all rsp_valid = 0.
  - While reset is high, c_ready = d_ready = 0 and rf_we = rf_re = 0.
  - A read granted in the cycle before reset asserts produces no response.
- **Data outputs when idle:** x_rdata1/2 hold 0 when x_rsp_valid = 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- **Defined:** the grant cycle's write (rd, wdata, we) is registered with the response.
  - If that write had we = 1 and rd != 0, and rd matches the granted rs1 (or rs2), the response substitutes the registered wdata for rdata1 (or rdata2).
  - This gives read-after-write forwarding within a single request.
- **Undefined:** no forwarding; the old value is returned. The extra pipeline registers are not synthesised.

Test Plan:
- Reset, then C writes x3 = 0xDEADBEEF, then C reads rs1 = 3, rs2 = 0 -> c_rsp_valid 1 cycle after grant, c_rdata1 = 0xDEADBEEF, c_rdata2 = 0; d_rsp_valid stays 0.
- C and D both valid continuously, STARVE_LIMIT = 4 -> C is granted 4 cycles, D is granted on the 5th, then the pattern repeats.
- Alternate C and D reads of x5 on consecutive cycles -> each response lands only on its owner, one per cycle, with no bubbles.
- C write x7 = 0x12345678 with read rs1 = 7 in one request -> old value (0) without REGFILE_BYPASS_EN; 0x12345678 with it.
- D writes x0 = 0xFFFFFFFF, then reads rs1 = 0 -> d_rdata1 = 0.
- C read granted, reset asserted the next cycle -> no c_rsp_valid; all outputs are 0 during reset.

Source files
------------

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: arbitrates core (C) and debug (D) access to one register file; REGFILE_BYPASS_EN forwards a request's own write into its read response
module regfile_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_valid,
    output logic        c_ready,
    input  logic        c_we,
    input  logic        c_re,
    input  logic [3:0]  c_rs1,
    input  logic [3:0]  c_rs2,
    input  logic [3:0]  c_rd,
    input  logic [31:0] c_wdata,
    output logic        c_rsp_valid,
    output logic [31:0] c_rdata1,
    output logic [31:0] c_rdata2,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic        d_we,
    input  logic        d_re,
    input  logic [3:0]  d_rs1,
    input  logic [3:0]  d_rs2,
    input  logic [3:0]  d_rd,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rdata1,
    output logic [31:0] d_rdata2,
    output logic        rf_we,
    output logic        rf_re,
    output logic [3:0]  rf_rs1,
    output logic [3:0]  rf_rs2,
    output logic [3:0]  rf_rd,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2
);
    logic [CNT_W-1:0] starve_cnt;
    logic             d_prio, gnt_c, gnt_d, rsp_c, rsp_d;
    logic [31:0]      rd1, rd2;
    // grant decision and register-file mux; core wins unless debug has starved long enough
    always_comb begin
        d_prio   = d_valid && starve_cnt == CNT_W'(STARVE_LIMIT);
        gnt_c    = !reset && c_valid && !d_prio;
        gnt_d    = !reset && d_valid && (d_prio || !c_valid);
        c_ready  = gnt_c;
        d_ready  = gnt_d;
        rf_we    = gnt_c ? c_we : gnt_d && d_we;
        rf_re    = gnt_c ? c_re : gnt_d && d_re;
        rf_rs1   = gnt_c ? c_rs1 : gnt_d ? d_rs1 : '0;
        rf_rs2   = gnt_c ? c_rs2 : gnt_d ? d_rs2 : '0;
        rf_rd    = gnt_c ? c_rd : gnt_d ? d_rd : '0;
        rf_wdata = gnt_c ? c_wdata : gnt_d ? d_wdata : '0;
    end
    // starvation counter and response owner/read flag captured at grant
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            rsp_c      <= 1'b0;
            rsp_d      <= 1'b0;
        end else begin
            starve_cnt <= (d_valid && gnt_c) ? (d_prio ? starve_cnt : starve_cnt + CNT_W'(1)) : '0;
            rsp_c      <= gnt_c && c_re;
            rsp_d      <= gnt_d && d_re;
        end
    end
`ifdef REGFILE_BYPASS_EN
    logic        byp_we;
    logic [3:0]  byp_rd, byp_rs1, byp_rs2;
    logic [31:0] byp_wdata;
    // keep the granted write next to its read so the response can forward it
    always_ff @(posedge clk) begin
        if (reset) begin
            byp_we <= 1'b0;
        end else begin
            byp_we <= rf_we && rf_rd != 4'd0;
        end
        byp_rd    <= rf_rd;
        byp_rs1   <= rf_rs1;
        byp_rs2   <= rf_rs2;
        byp_wdata <= rf_wdata;
    end
    // substitute the request's own write data when it targets a read address
    always_comb begin
        rd1 = (byp_we && byp_rd == byp_rs1) ? byp_wdata : rf_rdata1;
        rd2 = (byp_we && byp_rd == byp_rs2) ? byp_wdata : rf_rdata2;
    end
`else
    // no forwarding: the register file's old value is returned
    always_comb begin
        rd1 = rf_rdata1;
        rd2 = rf_rdata2;
    end
`endif
    // route read data to the owner only; reset suppresses any in-flight response
    always_comb begin
        c_rsp_valid = rsp_c && !reset;
        d_rsp_valid = rsp_d && !reset;
        c_rdata1    = c_rsp_valid ? rd1 : '0;
        c_rdata2    = c_rsp_valid ? rd2 : '0;
        d_rdata1    = d_rsp_valid ? rd1 : '0;
        d_rdata2    = d_rsp_valid ? rd2 : '0;
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed checks of regfile_arbiter against a behavioural register file
module tb_regfile_arbiter;
    logic        clk = 0, reset = 1;
    logic        c_valid, c_ready, c_we, c_re, c_rsp_valid;
    logic [3:0]  c_rs1, c_rs2, c_rd;
    logic [31:0] c_wdata, c_rdata1, c_rdata2;
    logic        d_valid, d_ready, d_we, d_re, d_rsp_valid;
    logic [3:0]  d_rs1, d_rs2, d_rd;
    logic [31:0] d_wdata, d_rdata1, d_rdata2;
    logic        rf_we, rf_re;
    logic [3:0]  rf_rs1, rf_rs2, rf_rd;
    logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;
    logic [31:0] mem [16];
    int total = 0, bad = 0;

    regfile_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_re(c_re),
        .c_rs1(c_rs1), .c_rs2(c_rs2), .c_rd(c_rd), .c_wdata(c_wdata),
        .c_rsp_valid(c_rsp_valid), .c_rdata1(c_rdata1), .c_rdata2(c_rdata2),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_re(d_re),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rdata1(d_rdata1), .d_rdata2(d_rdata2),
        .rf_we(rf_we), .rf_re(rf_re), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
    );

    always #5 clk = ~clk;

    // register file: x0 reads zero, registered reads return the pre-write value
    always @(posedge clk) begin
        if (rf_we && rf_rd != 4'd0) mem[rf_rd] <= rf_wdata;
        if (rf_re) begin
            rf_rdata1 <= (rf_rs1 == 4'd0) ? 32'd0 : mem[rf_rs1];
            rf_rdata2 <= (rf_rs2 == 4'd0) ? 32'd0 : mem[rf_rs2];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_valid = 0; c_we = 0; c_re = 0; c_rs1 = 0; c_rs2 = 0; c_rd = 0; c_wdata = 0;
        d_valid = 0; d_we = 0; d_re = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_wdata = 0;
    endtask

    task automatic set_c(input logic we, input logic re, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic [31:0] wd);
        c_valid = 1; c_we = we; c_re = re; c_rs1 = rs1; c_rs2 = rs2; c_rd = rd; c_wdata = wd;
    endtask

    task automatic set_d(input logic we, input logic re, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic [31:0] wd);
        d_valid = 1; d_we = we; d_re = re; d_rs1 = rs1; d_rs2 = rs2; d_rd = rd; d_wdata = wd;
    endtask

    task automatic test_reset();
        reset = 1;
        idle();
        set_c(1, 1, 4'd1, 4'd2, 4'd3, 32'h1111_1111);
        set_d(1, 1, 4'd1, 4'd2, 4'd3, 32'h2222_2222);
        tick();
        tick();
        total++; if ({c_ready, d_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {c_ready, d_ready}); end
        total++; if ({rf_we, rf_re} !== 2'b00) begin bad++; $display("FAIL reset_rf_en: got %b want 00", {rf_we, rf_re}); end
        total++; if ({c_rsp_valid, d_rsp_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp: got %b want 00", {c_rsp_valid, d_rsp_valid}); end
        idle();
        reset = 0;
        tick();
        total++; if ({c_rsp_valid, d_rsp_valid} !== 2'b00) begin bad++; $display("FAIL post_reset_rsp: got %b want 00", {c_rsp_valid, d_rsp_valid}); end
    endtask

    task automatic test_write_read();
        set_c(1, 0, 4'd0, 4'd0, 4'd3, 32'hDEAD_BEEF);
        #1;
        total++; if ({c_ready, d_ready, rf_we, rf_re} !== 4'b1010) begin bad++; $display("FAIL wr_ctrl: got %b want 1010", {c_ready, d_ready, rf_we, rf_re}); end
        total++; if (rf_rd !== 4'd3 || rf_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_fields: got rd=%0d wd=%h want rd=3 wd=deadbeef", rf_rd, rf_wdata); end
        tick();
        set_c(0, 1, 4'd3, 4'd0, 4'd0, 32'd0);
        #1;
        total++; if (c_rsp_valid !== 1'b0) begin bad++; $display("FAIL write_only_rsp: got %b want 0", c_rsp_valid); end
        total++; if (rf_re !== 1'b1 || rf_rs1 !== 4'd3) begin bad++; $display("FAIL rd_ctrl: got re=%b rs1=%0d want re=1 rs1=3", rf_re, rf_rs1); end
        tick();
        idle();
        #1;
        total++; if (c_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_rsp_valid: got c=%b d=%b want c=1 d=0", c_rsp_valid, d_rsp_valid); end
        total++; if (c_rdata1 !== 32'hDEAD_BEEF || c_rdata2 !== 32'd0) begin bad++; $display("FAIL rd_data: got %h %h want deadbeef 00000000", c_rdata1, c_rdata2); end
        total++; if ({rf_we, rf_re, rf_rd, rf_rs1, rf_wdata} !== 46'd0) begin bad++; $display("FAIL idle_rf: got we=%b re=%b rd=%0d rs1=%0d wd=%h want all zero", rf_we, rf_re, rf_rd, rf_rs1, rf_wdata); end
        tick();
        total++; if (c_rsp_valid !== 1'b0 || c_rdata1 !== 32'd0) begin bad++; $display("FAIL rsp_idle: got v=%b d=%h want 0 0", c_rsp_valid, c_rdata1); end
    endtask

    task automatic test_starve();
        logic exp_c;
        set_c(0, 0, 4'd0, 4'd0, 4'd1, 32'd0);
        set_d(0, 0, 4'd0, 4'd0, 4'd2, 32'd0);
        for (int i = 0; i < 10; i++) begin
            exp_c = (i % 5) != 4;
            #1;
            total++; if (c_ready !== exp_c || d_ready !== !exp_c) begin bad++; $display("FAIL starve_grant[%0d]: got c=%b d=%b want c=%b d=%b", i, c_ready, d_ready, exp_c, !exp_c); end
            total++; if (rf_rd !== (exp_c ? 4'd1 : 4'd2)) begin bad++; $display("FAIL starve_mux[%0d]: got rd=%0d want %0d", i, rf_rd, exp_c ? 1 : 2); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_alternate();
        set_c(1, 0, 4'd0, 4'd0, 4'd5, 32'hA5A5_0005);
        tick();
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i < 6) begin
                if (i % 2 == 0) set_c(0, 1, 4'd5, 4'd0, 4'd0, 32'd0);
                else            set_d(0, 1, 4'd5, 4'd5, 4'd0, 32'd0);
            end
            #1;
            if (i > 0) begin
                if ((i - 1) % 2 == 0) begin
                    total++; if (c_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b0 || c_rdata1 !== 32'hA5A5_0005 || d_rdata1 !== 32'd0) begin
                        bad++; $display("FAIL alt_c[%0d]: got cv=%b dv=%b c1=%h d1=%h want 1 0 a5a50005 0", i, c_rsp_valid, d_rsp_valid, c_rdata1, d_rdata1);
                    end
                end else begin
                    total++; if (d_rsp_valid !== 1'b1 || c_rsp_valid !== 1'b0 || d_rdata1 !== 32'hA5A5_0005 || d_rdata2 !== 32'hA5A5_0005) begin
                        bad++; $display("FAIL alt_d[%0d]: got cv=%b dv=%b d1=%h d2=%h want 0 1 a5a50005 a5a50005", i, c_rsp_valid, d_rsp_valid, d_rdata1, d_rdata2);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_raw();
        logic [31:0] exp1;
`ifdef REGFILE_BYPASS_EN
        exp1 = 32'h1234_5678;
`else
        exp1 = 32'd0;
`endif
        idle();
        set_c(1, 1, 4'd7, 4'd0, 4'd7, 32'h1234_5678);
        tick();
        set_c(0, 1, 4'd7, 4'd7, 4'd0, 32'd0);
        #1;
        total++; if (c_rsp_valid !== 1'b1 || c_rdata1 !== exp1 || c_rdata2 !== 32'd0) begin bad++; $display("FAIL raw_same: got v=%b d1=%h d2=%h want 1 %h 0", c_rsp_valid, c_rdata1, c_rdata2, exp1); end
        tick();
        idle();
        #1;
        total++; if (c_rdata1 !== 32'h1234_5678 || c_rdata2 !== 32'h1234_5678) begin bad++; $display("FAIL raw_after: got %h %h want 12345678 12345678", c_rdata1, c_rdata2); end
        tick();
    endtask

    task automatic test_x0();
        set_d(1, 0, 4'd0, 4'd0, 4'd0, 32'hFFFF_FFFF);
        #1;
        total++; if (d_ready !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 4'd0 || rf_wdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL x0_write: got rdy=%b we=%b rd=%0d wd=%h want 1 1 0 ffffffff", d_ready, rf_we, rf_rd, rf_wdata); end
        tick();
        set_d(0, 1, 4'd0, 4'd3, 4'd0, 32'd0);
        tick();
        idle();
        #1;
        total++; if (d_rsp_valid !== 1'b1 || d_rdata1 !== 32'd0 || d_rdata2 !== 32'hDEAD_BEEF || c_rsp_valid !== 1'b0) begin bad++; $display("FAIL x0_read: got dv=%b d1=%h d2=%h cv=%b want 1 0 deadbeef 0", d_rsp_valid, d_rdata1, d_rdata2, c_rsp_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_c(0, 1, 4'd3, 4'd0, 4'd0, 32'd0);
        tick();
        reset = 1;
        set_d(1, 1, 4'd3, 4'd3, 4'd4, 32'h5);
        #1;
        total++; if (c_rsp_valid !== 1'b0 || c_rdata1 !== 32'd0) begin bad++; $display("FAIL rst_mid_rsp: got v=%b d=%h want 0 0", c_rsp_valid, c_rdata1); end
        total++; if ({c_ready, d_ready, rf_we, rf_re} !== 4'b0000) begin bad++; $display("FAIL rst_mid_ctrl: got %b want 0000", {c_ready, d_ready, rf_we, rf_re}); end
        tick();
        reset = 0;
        idle();
        tick();
        total++; if ({c_rsp_valid, d_rsp_valid} !== 2'b00) begin bad++; $display("FAIL rst_mid_after: got %b want 00", {c_rsp_valid, d_rsp_valid}); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        rf_rdata1 = 32'd0;
        rf_rdata2 = 32'd0;
        idle();
        test_reset();
        test_write_read();
        test_starve();
        test_alternate();
        test_raw();
        test_x0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
